// File: rtl/memory_sq.sv
// memory_sq: byte-addressed little-endian data memory with an in-order store queue.
// Define MISALIGN_TRAP_EN to add a registered misalign output that traps unaligned accesses.
module memory_sq #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 1024,
  parameter int SQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] write_data,
  input  logic            write,
  input  logic [1:0]      size,
  input  logic            load_unsigned,
  input  logic            en_wb,
  input  logic [4:0]      reg_write,
  output logic [XLEN-1:0] read_data,
  output logic            en_wb_out,
  output logic [4:0]      reg_write_out,
  output logic            stall
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(SQ_DEPTH);
  localparam logic [PW:0] FullCnt = (PW+1)'(SQ_DEPTH);

  logic [XLEN-1:0]     mem      [DEPTH];
  logic [IW-1:0]       sqIdx_q  [SQ_DEPTH];
  logic [3:0]          sqMask_q [SQ_DEPTH];
  logic [XLEN-1:0]     sqData_q [SQ_DEPTH];
  logic [SQ_DEPTH-1:0] sqValid_q, sqValid_d;
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [PW:0]         count_q, count_d;
  logic [XLEN-1:0]     readData_q, readData_d;
  logic                enWb_q, enWb_d;
  logic [4:0]          regWr_q, regWr_d;

  logic [IW-1:0]   wordIdx;
  logic [1:0]      lane;
  logic [3:0]      storeMask;
  logic [XLEN-1:0] storeData, loadShift, loadVal;
  logic            hazard, accept, trap, enqueue, drain;
  logic            unusedAddr;

  assign wordIdx    = addr[IW+1:2];
  assign unusedAddr = ^addr[XLEN-1:IW+2];

  // Low address bits not belonging to the access size are dropped here.
  always_comb begin
    lane      = 2'd0;
    storeMask = 4'b1111;
    case (size)
      2'd0: begin
        lane      = addr[1:0];
        storeMask = 4'b0001 << addr[1:0];
      end
      2'd1: begin
        lane      = {addr[1], 1'b0};
        storeMask = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        lane      = 2'd0;
        storeMask = 4'b1111;
      end
    endcase
  end

  assign storeData = write_data << {lane, 3'b000};
  assign loadShift = mem[wordIdx] >> {lane, 3'b000};

  always_comb begin
    loadVal = loadShift;
    case (size)
      2'd0:    loadVal = {{(XLEN-8){~load_unsigned & loadShift[7]}}, loadShift[7:0]};
      2'd1:    loadVal = {{(XLEN-16){~load_unsigned & loadShift[15]}}, loadShift[15:0]};
      default: loadVal = loadShift;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (sqValid_q[i] && (sqIdx_q[i] == wordIdx)) hazard = 1'b1;
    end
  end

  assign stall  = en && (write ? (count_q == FullCnt) : hazard);
  assign accept = en && !stall;

`ifdef MISALIGN_TRAP_EN
  logic misaligned, misalign_q;
  assign misaligned = ((size == 2'd1) && addr[0]) || (size[1] && (addr[1:0] != 2'd0));
  assign trap       = accept && misaligned;
  assign misalign   = misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= trap;
  end
`else
  assign trap = 1'b0;
`endif

  assign enqueue = accept && write && !trap;
  assign drain   = !accept && (count_q != '0);

  // Enqueue and drain are mutually exclusive: drain only runs on idle/stalled cycles.
  always_comb begin
    sqValid_d = sqValid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (enqueue) begin
      sqValid_d[tail_q] = 1'b1;
      tail_d            = tail_q + 1'b1;
      count_d           = count_q + 1'b1;
    end
    if (drain) begin
      sqValid_d[head_q] = 1'b0;
      head_d            = head_q + 1'b1;
      count_d           = count_q - 1'b1;
    end
  end

  always_comb begin
    readData_d = readData_q;
    enWb_d     = 1'b0;
    regWr_d    = regWr_q;
    if (accept && !trap) begin
      enWb_d  = en_wb;
      regWr_d = reg_write;
      if (!write) readData_d = loadVal;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sqValid_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      readData_q <= '0;
      enWb_q     <= 1'b0;
      regWr_q    <= '0;
    end else begin
      sqValid_q  <= sqValid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      readData_q <= readData_d;
      enWb_q     <= enWb_d;
      regWr_q    <= regWr_d;
    end
  end

  // Queue payload and the array itself carry no reset.
  always_ff @(posedge clk) begin
    if (enqueue) begin
      sqIdx_q[tail_q]  <= wordIdx;
      sqMask_q[tail_q] <= storeMask;
      sqData_q[tail_q] <= storeData;
    end
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (sqMask_q[head_q][b]) mem[sqIdx_q[head_q]][8*b +: 8] <= sqData_q[head_q][8*b +: 8];
      end
    end
  end

  assign read_data     = readData_q;
  assign en_wb_out     = enWb_q;
  assign reg_write_out = regWr_q;

endmodule

// File: doc/memory_sq.md
MEMORY_SQ -- requirements
Module: memory_sq

Interface
REQ-001 Parameter XLEN, 32, data/address width; only 32 supported.
REQ-002 Parameter DEPTH, 1024, array size in 32-bit words; power of 2.
REQ-003 Parameter SQ_DEPTH, 4, store-queue entries; power of 2, >=2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  access request valid this cycle.
REQ-007 addr  in  XLEN  byte address; bits above log2(DEPTH*4) ignored, so addresses wrap.
REQ-008 write_data  in  XLEN  store data, right-aligned.
REQ-009 write  in  1  1 = store, 0 = load.
REQ-010 size  in  2  0 = byte, 1 = half, 2 = word; 3 treated as word.
REQ-011 load_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
REQ-012 en_wb, reg_write  in  1, 5  write-back enable and destination register, carried alongside the access.
REQ-013 read_data  out  XLEN  registered load result.
REQ-014 en_wb_out, reg_write_out  out  1, 5  registered copies of en_wb and reg_write.
REQ-015 stall  out  1  combinational; 1 = request not accepted this cycle; upstream holds all inputs.

Function
REQ-016 Request accepted SHALL mean en=1 and stall=0.
REQ-017 Memory SHALL be byte-addressed and little-endian: word index addr[log2(DEPTH)+1:2], lane addr[1:0].
REQ-018 Accepted load: read_data, en_wb_out and reg_write_out SHALL update at the next rising edge (1-cycle latency).
REQ-019 Load extraction: byte = lane addr[1:0], half = lanes addr[1]*2..+1, word = all 4 lanes; extended per load_unsigned.
REQ-020 Accepted store SHALL enqueue {word index, 4-bit byte mask, lane-shifted data} at the queue tail; the array is not written that cycle.
REQ-021 On a store cycle, en_wb_out SHALL follow en_wb and read_data SHALL hold its value.
REQ-022 Drain: on any cycle with no accepted request and a non-empty queue, the head entry SHALL be written to the array under its byte mask, then dequeued; one entry per cycle.
REQ-023 Load hazard: stall=1 when a load's word index equals any valid queue entry's word index, regardless of mask.
REQ-024 Full: stall=1 for a store when the queue holds SQ_DEPTH entries.
REQ-025 A stalled cycle counts as no accepted request, so the drain proceeds and stall always clears within SQ_DEPTH cycles.
REQ-026 On stall or en=0, en_wb_out SHALL be 0 next cycle (bubble); reg_write_out and read_data hold.
REQ-027 Stores SHALL retire to the array in program order; two queued stores to the same word SHALL both apply in order.
REQ-028 Without MISALIGN_TRAP_EN, misaligned low address bits SHALL be forced to zero (half: bit 0; word: bits 1:0).

Reset
REQ-029 While rst=0: queue empty, stall=0, read_data=0, en_wb_out=0, reg_write_out=0.
REQ-030 Reset mid-operation SHALL discard all queued stores; array contents are not reset and are unspecified until written.

Configuration
REQ-031 Macro MISALIGN_TRAP_EN compiled in: add output misalign (1 bit, registered, reset 0).
REQ-032 Under MISALIGN_TRAP_EN, an accepted misaligned half or word access SHALL set misalign=1 the next cycle, enqueue nothing, force en_wb_out=0 and hold read_data; otherwise misalign=0.
REQ-033 Without MISALIGN_TRAP_EN there is no misalign port, and REQ-028 applies.

Verification
REQ-034 Stores word 0xFFFFFFFF@0, half 0xAAAA@0, byte 0x55@0, then idle 3 cycles and load word @0 -> read_data=0xFFFFAA55.
REQ-035 Store word 0x8000@8, load half @8: unsigned -> 0x00008000; signed -> 0xFFFF8000; byte 0x80@12 loaded unsigned/signed -> 0x00000080 / 0xFFFFFF80.
REQ-036 4 back-to-back stores to @16,20,24,28, then a 5th store -> stall=1 exactly 1 cycle, then accepted; no stall on the first 4.
REQ-037 Store 0x12345678@32, then an immediate load @32 -> stall=1 for 1 cycle, en_wb_out=0 that cycle; load then returns 0x12345678.
REQ-038 Reset asserted with 3 queued stores to @40 -> after release, loads @40 do not stall and every output reads its reset value.
REQ-039 With MISALIGN_TRAP_EN, word store @2 -> misalign=1 next cycle, en_wb_out=0; a subsequent load @0 shows the prior contents unchanged.
